wash_cycle_ctrl: RTL and testbench

Sequencer for the washing-machine datapath. Steps a wash program through fill, wash, rinse and spin, and drives the 3-bit ctrl mode code the datapath consumes. Also drives the valve, lock and status signals. Sits between the front-panel inputs (start, cancel, lid and level sensors) and the datapath/actuator block.

---
 rtl/wash_pkg.sv | 39 +++
 rtl/wash_timer.sv | 30 +++
 rtl/wash_cycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and constants for the wash-cycle sequencer.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5,
    ST_PAUSE = 3'd6,
    ST_FAULT = 3'd7
  } state_e;

  localparam logic [2:0] CTRL_OFF   = 3'd0;
  localparam logic [2:0] CTRL_FILL  = 3'd1;
  localparam logic [2:0] CTRL_WASH  = 3'd2;
  localparam logic [2:0] CTRL_RINSE = 3'd3;
  localparam logic [2:0] CTRL_SPIN  = 3'd4;
  localparam logic [2:0] CTRL_FAULT = 3'd7;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_PAUSED    = 1;
  localparam int unsigned STAT_FAULT     = 2;
  localparam int unsigned STAT_DONE      = 3;
  localparam int unsigned STAT_STATE_LSB = 4;
  localparam int unsigned STAT_LOCK      = 7;

  // States that run the down-counter.
  function automatic logic is_timed(input state_e s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

  // States in which the drum is closed and actively working.
  function automatic logic is_active(input state_e s);
    return is_timed(s);
  endfunction

endpackage

// File: rtl/wash_timer.sv
// Loadable down-counter that stops at zero and can be frozen.
module wash_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             freeze,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load has priority over freeze; the counter saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!freeze && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Terminal-count flag.
  always_comb begin
    zero = (count == '0);
  end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash program sequencer: fill, wash, rinse, spin, with lid pause and fill fault.
module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned FILL_TICKS  = 8,
  parameter int unsigned WASH_TICKS  = 16,
  parameter int unsigned RINSE_TICKS = 8,
  parameter int unsigned SPIN_TICKS  = 12,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic             lid_open,
  input  logic             water_full,
  output logic [2:0]       ctrl,
  output logic             fill_valve,
  output logic             drain_valve,
  output logic             door_lock,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic [7:0]       status
);

  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_TICKS - 1);
  localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_TICKS - 1);
  localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_TICKS - 1);

  state_e           state;
  state_e           state_nx;
  state_e           saved;
  state_e           saved_nx;
  logic             tmr_load;
  logic             tmr_freeze;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] count;
  logic             tmr_zero;

  wash_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .freeze   (tmr_freeze),
    .count    (count),
    .zero     (tmr_zero)
  );

  // State and paused-from state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      saved <= ST_IDLE;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
    end
  end

  // Next state: cancel beats lid, lid beats timer/sensor events.
  always_comb begin
    state_nx = state;
    saved_nx = saved;
    if ((state != ST_IDLE) && cancel) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !lid_open && !cancel) state_nx = ST_FILL;
        end
        ST_FILL: begin
          if (water_full)    state_nx = ST_WASH;
          else if (tmr_zero) state_nx = ST_FAULT;
        end
        ST_WASH, ST_RINSE, ST_SPIN: begin
          if (lid_open) begin
            saved_nx = state;
            state_nx = ST_PAUSE;
          end else if (tmr_zero) begin
            case (state)
              ST_WASH:  state_nx = ST_RINSE;
              ST_RINSE: state_nx = ST_SPIN;
              default:  state_nx = ST_DONE;
            endcase
          end
        end
        ST_DONE:  state_nx = ST_IDLE;
        ST_PAUSE: begin
          if (!lid_open) state_nx = saved;
        end
        ST_FAULT: state_nx = ST_FAULT;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Timer control: load on fresh entry to a timed state, hold while paused.
  always_comb begin
    tmr_freeze = (state == ST_PAUSE);
    tmr_load   = (state_nx != state) && (state != ST_PAUSE) && is_timed(state_nx);
    case (state_nx)
      ST_FILL:  tmr_val = FILL_LOAD;
      ST_WASH:  tmr_val = WASH_LOAD;
      ST_RINSE: tmr_val = RINSE_LOAD;
      ST_SPIN:  tmr_val = SPIN_LOAD;
      default:  tmr_val = '0;
    endcase
  end

  // Output decode from registered state and timer.
  always_comb begin
    ctrl        = CTRL_OFF;
    fill_valve  = 1'b0;
    drain_valve = 1'b0;
    door_lock   = is_active(state);
    done        = (state == ST_DONE);
    remaining   = '0;
    status      = '0;
    case (state)
      ST_FILL:  ctrl = CTRL_FILL;
      ST_WASH:  ctrl = CTRL_WASH;
      ST_RINSE: ctrl = CTRL_RINSE;
      ST_SPIN:  ctrl = CTRL_SPIN;
      ST_FAULT: ctrl = CTRL_FAULT;
      default:  ctrl = CTRL_OFF;
    endcase
    fill_valve  = (state == ST_FILL);
    drain_valve = (state == ST_SPIN);
    if (is_timed(state) || (state == ST_PAUSE)) remaining = count;
    status[STAT_BUSY]               = is_active(state) || (state == ST_PAUSE);
    status[STAT_PAUSED]             = (state == ST_PAUSE);
    status[STAT_FAULT]              = (state == ST_FAULT);
    status[STAT_DONE]               = (state == ST_DONE);
    status[STAT_STATE_LSB +: 3]     = 3'(state);
    status[STAT_LOCK]               = is_active(state);
  end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for the wash-cycle sequencer.
module tb_wash_cycle_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_RINSE = 3'd3;
  localparam logic [2:0] S_SPIN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_PAUSE = 3'd6;
  localparam logic [2:0] S_FAULT = 3'd7;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       cancel;
    logic       lid;
    logic       water;
    logic [2:0] st;
    logic [7:0] rem;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cancel;
  logic       lid_open;
  logic       water_full;
  logic [2:0] ctrl;
  logic       fill_valve;
  logic       drain_valve;
  logic       door_lock;
  logic       done;
  logic [7:0] remaining;
  logic [7:0] status;

  int checks   = 0;
  int failures = 0;

  vec_t tbl [16];

  wash_cycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cancel      (cancel),
    .lid_open    (lid_open),
    .water_full  (water_full),
    .ctrl        (ctrl),
    .fill_valve  (fill_valve),
    .drain_valve (drain_valve),
    .door_lock   (door_lock),
    .done        (done),
    .remaining   (remaining),
    .status      (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_status(input logic [2:0] st);
    case (st)
      S_IDLE:  return 8'h00;
      S_FILL:  return 8'h91;
      S_WASH:  return 8'hA1;
      S_RINSE: return 8'hB1;
      S_SPIN:  return 8'hC1;
      S_DONE:  return 8'h58;
      S_PAUSE: return 8'h63;
      default: return 8'h74;
    endcase
  endfunction

  function automatic logic [2:0] exp_ctrl(input logic [2:0] st);
    case (st)
      S_FILL, S_WASH, S_RINSE, S_SPIN: return st;
      S_FAULT: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic s, input logic c, input logic l, input logic w);
    rst        = r;
    start      = s;
    cancel     = c;
    lid_open   = l;
    water_full = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [7:0] rem);
    logic [22:0] act;
    logic [22:0] exp;
    logic        lock;
    lock = (st >= S_FILL) && (st <= S_SPIN);
    act  = {ctrl, fill_valve, drain_valve, door_lock, done, remaining, status};
    exp  = {exp_ctrl(st), st == S_FILL, st == S_SPIN, lock, st == S_DONE, rem, exp_status(st)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got ctrl=%0d fill=%b drain=%b lock=%b done=%b rem=%0d status=%h; want ctrl=%0d fill=%b drain=%b lock=%b done=%b rem=%0d status=%h",
               name, $time, ctrl, fill_valve, drain_valve, door_lock, done, remaining, status,
               exp[22:20], exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; lid_open = 1'b0; water_full = 1'b0;

    // Reset, start blocked by open lid, fill timeout, fault hold, cancel.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE,  8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, S_IDLE,  8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, S_IDLE,  8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, S_IDLE,  8'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_FILL,  8'd7};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FILL,  8'd6};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FILL,  8'd5};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FILL,  8'd4};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FILL,  8'd3};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FILL,  8'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FILL,  8'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FILL,  8'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FAULT, 8'd0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_FAULT, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE,  8'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE,  8'd0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].cancel, tbl[i].lid, tbl[i].water);
      check($sformatf("tbl%0d", i), tbl[i].st, tbl[i].rem);
    end

    // Normal run: water arrives during the 3rd FILL cycle; done in cycle 40.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("run_c1", S_FILL, 8'd7);
    for (int c = 2; c <= 41; c++) begin
      logic [2:0] st;
      logic [7:0] rem;
      step(1'b0, 1'b0, 1'b0, 1'b0, c >= 4);
      if (c <= 3)       begin st = S_FILL;  rem = 8'(8 - c);  end
      else if (c <= 19) begin st = S_WASH;  rem = 8'(19 - c); end
      else if (c <= 27) begin st = S_RINSE; rem = 8'(27 - c); end
      else if (c <= 39) begin st = S_SPIN;  rem = 8'(39 - c); end
      else if (c == 40) begin st = S_DONE;  rem = 8'd0;       end
      else              begin st = S_IDLE;  rem = 8'd0;       end
      check($sformatf("run_c%0d", c), st, rem);
    end

    // Pause in WASH with PAUSE showing 10, then cancel+lid together in RINSE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pz_fill", S_FILL, 8'd7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pz_wash15", S_WASH, 8'd15);
    for (int k = 14; k >= 11; k--) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("pz_wash%0d", k), S_WASH, 8'(k));
    end
    for (int p = 0; p < 5; p++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check($sformatf("pz_pause%0d", p), S_PAUSE, 8'd10);
    end
    for (int k = 10; k >= 0; k--) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("pz_resume%0d", k), S_WASH, 8'(k));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pz_rinse", S_RINSE, 8'd7);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("cancel_beats_lid", S_IDLE, 8'd0);

    // Lid ignored in FILL; water on the timer-zero edge wins over fault.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fz_fill7", S_FILL, 8'd7);
    for (int k = 6; k >= 0; k--) begin
      step(1'b0, 1'b1, 1'b0, (k == 4) || (k == 3), 1'b0);
      check($sformatf("fz_fill%0d", k), S_FILL, 8'(k));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fz_water_wins", S_WASH, 8'd15);

    // Run through to SPIN, then reset mid-SPIN.
    for (int k = 14; k >= 0; k--) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("rs_wash%0d", k), S_WASH, 8'(k));
    end
    for (int k = 7; k >= 0; k--) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("rs_rinse%0d", k), S_RINSE, 8'(k));
    end
    for (int k = 11; k >= 8; k--) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("rs_spin%0d", k), S_SPIN, 8'(k));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rs_reset", S_IDLE, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rs_idle", S_IDLE, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
